// File: rtl/core_axi_pkg.sv
// rtl/core_axi_pkg.sv - shared constants and helpers for the core AXI4-Lite master
//
// Purpose: state encoding of the master FSM, AXI response and protection
// codes, and the response-to-error mapping used by the master.
// Ports: none (package).
package core_axi_pkg;

  // Master FSM states
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WRESP      = 3'd2;
  localparam logic [2:0] ST_RADDR      = 3'd3;
  localparam logic [2:0] ST_RDATA      = 3'd4;
  localparam logic [2:0] ST_RESP       = 3'd5;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Only OKAY counts as success; EXOKAY is unexpected on AXI4-Lite and is
  // reported as an error along with SLVERR and DECERR.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      AXI_RESP_OKAY:   err = 1'b0;
      AXI_RESP_EXOKAY: err = 1'b1;
      AXI_RESP_SLVERR: err = 1'b1;
      AXI_RESP_DECERR: err = 1'b1;
      default:         err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/core_axi_vld_hold.sv
// rtl/core_axi_vld_hold.sv - registered VALID flag with held payload for one AXI channel
//
// Purpose: raises VALID with a payload on load and keeps both stable until
// the VALID&READY handshake, after which VALID drops the next cycle.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset (clears flag and payload)
//   load      start a new transfer with load_data
//   load_data payload to present
//   ready     channel READY from the slave
//   valid     channel VALID to the slave (registered)
//   data      channel payload to the slave (registered)
module core_axi_vld_hold #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      // Payload is left in place; only the flag drops after the handshake.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/core_axi_master.sv
// rtl/core_axi_master.sv - single-outstanding AXI4-Lite initiator with command/response ports
//
// Purpose: accepts one read or write command at a time, runs the AW/W/B or
// AR/R channel sequence on the AXI4-Lite bus and returns read data plus an
// error flag on the response port.
// Ports:
//   M_AXI_ACLK, M_AXI_ARST        clock, synchronous active-high reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA/WSTRB   command port (valid/ready)
//   RSP_VALID/READY/RDATA/ERR     response port (valid/ready)
//   BUSY                          high whenever a command is in flight
//   M_AXI_AW*/W*/B*/AR*/R*        AXI4-Lite master channels
module core_axi_master
  import core_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARST,
  // command port
  input  logic                              CMD_VALID,
  output logic                              CMD_READY,
  input  logic                              CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
  // response port
  output logic                              RSP_VALID,
  input  logic                              RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
  output logic                              RSP_ERR,
  output logic                              BUSY,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int WPL_W  = C_M_AXI_DATA_WIDTH + STRB_W;

  logic [2:0]                    state;
  logic                          cmd_ready_q;
  logic                          rsp_valid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                          rsp_err_q;
  logic                          bready_q;
  logic                          rready_q;

  logic                          accept;
  logic                          aw_fin;
  logic                          w_fin;
  logic [WPL_W-1:0]              w_payload;

  assign accept = (state == ST_IDLE) && cmd_ready_q && CMD_VALID;

  // A write channel is finished once its VALID has already dropped or is
  // being accepted on this edge; AW and W may complete in either order.
  assign aw_fin = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_fin  = !M_AXI_WVALID  || M_AXI_WREADY;

  core_axi_vld_hold #(.W(C_M_AXI_ADDR_WIDTH)) u_aw_hold (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARST),
    .load      (accept && CMD_WRITE),
    .load_data (CMD_ADDR),
    .ready     (M_AXI_AWREADY),
    .valid     (M_AXI_AWVALID),
    .data      (M_AXI_AWADDR)
  );

  core_axi_vld_hold #(.W(WPL_W)) u_w_hold (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARST),
    .load      (accept && CMD_WRITE),
    .load_data ({CMD_WSTRB, CMD_WDATA}),
    .ready     (M_AXI_WREADY),
    .valid     (M_AXI_WVALID),
    .data      (w_payload)
  );

  core_axi_vld_hold #(.W(C_M_AXI_ADDR_WIDTH)) u_ar_hold (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARST),
    .load      (accept && !CMD_WRITE),
    .load_data (CMD_ADDR),
    .ready     (M_AXI_ARREADY),
    .valid     (M_AXI_ARVALID),
    .data      (M_AXI_ARADDR)
  );

  assign M_AXI_WDATA  = w_payload[C_M_AXI_DATA_WIDTH-1:0];
  assign M_AXI_WSTRB  = w_payload[WPL_W-1:C_M_AXI_DATA_WIDTH];
  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;
  assign M_AXI_BREADY = bready_q;
  assign M_AXI_RREADY = rready_q;

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign BUSY      = (state != ST_IDLE);

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARST) begin
      state       <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // CMD_READY is raised one cycle after entering IDLE, both after
          // reset and after a response handshake.
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (CMD_VALID) begin
            cmd_ready_q <= 1'b0;
            state       <= CMD_WRITE ? ST_WADDR_DATA : ST_RADDR;
          end
        end
        ST_WADDR_DATA: begin
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state    <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_AXI_BVALID && bready_q) begin
            bready_q    <= 1'b0;
            rsp_err_q   <= resp_is_err(M_AXI_BRESP);
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RADDR: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            rready_q <= 1'b1;
            state    <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (M_AXI_RVALID && rready_q) begin
            rready_q    <= 1'b0;
            rsp_err_q   <= resp_is_err(M_AXI_RRESP);
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
